// File: rtl/int_ack_sequencer.sv
// Priority resolver and two-pulse INTA sequencer for an 8259-style PIC core.
// Owns the ISR. Produces INT, clear_IRR, the vector byte and the end/abort pulses.
module int_ack_sequencer #(
   parameter int ACK_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       init,
   input  logic [7:0] irr,
   input  logic [7:0] int_mask,
   input  logic [7:0] eoi,
   input  logic [2:0] priority_rotate,
   input  logic       auto_eoi,
   input  logic [4:0] vector_base,
   input  logic       int_ack,
   output logic       INT,
   output logic [7:0] isr,
   output logic [7:0] highest_level_in_service,
   output logic [7:0] clear_IRR,
   output logic [7:0] vector_out,
   output logic       vector_valid,
   output logic       end_of_ack,
   output logic       ack_timeout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PEND  = 3'd1;
   localparam logic [2:0] S_ACK1  = 3'd2;
   localparam logic [2:0] S_WAIT2 = 3'd3;
   localparam logic [2:0] S_ACK2  = 3'd4;

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TIMEOUT);

   logic [2:0]       state_reg, state_next;
   logic             int_reg, int_next;
   logic [7:0]       isr_reg, isr_next;
   logic [7:0]       clear_irr_reg, clear_irr_next;
   logic [7:0]       vector_out_reg, vector_out_next;
   logic             vector_valid_reg, vector_valid_next;
   logic             end_of_ack_reg, end_of_ack_next;
   logic             ack_timeout_reg, ack_timeout_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] cnt_inc;
   logic [2:0]       level_reg, level_next;
   logic             spurious_reg, spurious_next;
   logic             int_ack_q;

   logic [7:0] eligible;
   logic [7:0] elig_rot;
   logic [7:0] isr_rot;
   logic       elig_found, isr_found;
   logic [2:0] elig_k, isr_k;
   logic       winner_valid;
   logic [2:0] winner_level;
   logic [2:0] isr_level;
   logic       ack_rise, ack_fall;
   logic [7:0] isr_set;
   logic [7:0] isr_auto_clr;

   assign eligible = irr & ~int_mask;

   // Rotated views: bit 0 is always the current highest-priority level.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rot
         assign elig_rot[gi] = eligible[3'(gi) + priority_rotate + 3'd1];
         assign isr_rot[gi]  = isr_reg[3'(gi) + priority_rotate + 3'd1];
      end
   endgenerate

   always_comb begin
      elig_found = 1'b0;
      elig_k     = 3'd0;
      isr_found  = 1'b0;
      isr_k      = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (elig_rot[i]) begin
            elig_found = 1'b1;
            elig_k     = 3'(i);
         end
         if (isr_rot[i]) begin
            isr_found = 1'b1;
            isr_k     = 3'(i);
         end
      end
   end

   // Fully nested: a request must outrank the highest level already in service.
   assign winner_valid = elig_found && (!isr_found || (elig_k < isr_k));
   assign winner_level = elig_k + priority_rotate + 3'd1;
   assign isr_level    = isr_k + priority_rotate + 3'd1;

   assign ack_rise = int_ack & ~int_ack_q;
   assign ack_fall = ~int_ack & int_ack_q;
   assign cnt_inc  = cnt_reg + CNT_W'(1);

   always_comb begin
      state_next        = state_reg;
      int_next          = int_reg;
      level_next        = level_reg;
      spurious_next     = spurious_reg;
      cnt_next          = cnt_reg;
      vector_out_next   = vector_out_reg;
      vector_valid_next = vector_valid_reg;
      clear_irr_next    = 8'd0;
      end_of_ack_next   = 1'b0;
      ack_timeout_next  = 1'b0;
      isr_set           = 8'd0;
      isr_auto_clr      = 8'd0;

      case (state_reg)
         S_IDLE: begin
            if (winner_valid) begin
               state_next = S_PEND;
               int_next   = 1'b1;
            end
         end
         S_PEND: begin
            if (ack_rise) begin
               state_next = S_ACK1;
               if (winner_valid) begin
                  level_next     = winner_level;
                  spurious_next  = 1'b0;
                  isr_set        = 8'd1 << winner_level;
                  clear_irr_next = 8'd1 << winner_level;
               end else begin
                  // Request withdrawn on the same edge: answer with spurious IR7.
                  level_next    = 3'd7;
                  spurious_next = 1'b1;
               end
            end else if (!winner_valid) begin
               state_next = S_IDLE;
               int_next   = 1'b0;
            end
         end
         S_ACK1: begin
            if (ack_fall) begin
               state_next = S_WAIT2;
               cnt_next   = '0;
            end
         end
         S_WAIT2: begin
            if (ack_rise) begin
               state_next        = S_ACK2;
               vector_valid_next = 1'b1;
               vector_out_next   = {vector_base, level_reg};
            end else if (cnt_inc == TIMEOUT_VAL) begin
               state_next       = S_IDLE;
               int_next         = 1'b0;
               ack_timeout_next = 1'b1;
               if (!spurious_reg) begin
                  isr_auto_clr = 8'd1 << level_reg;
               end
            end else begin
               cnt_next = cnt_inc;
            end
         end
         S_ACK2: begin
            if (ack_fall) begin
               state_next        = S_IDLE;
               int_next          = 1'b0;
               vector_valid_next = 1'b0;
               end_of_ack_next   = 1'b1;
               if (auto_eoi && !spurious_reg) begin
                  isr_auto_clr = 8'd1 << level_reg;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
            int_next   = 1'b0;
         end
      endcase

      // A set on the same bit as an EOI wins.
      isr_next = (isr_reg & ~eoi & ~isr_auto_clr) | isr_set;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= S_IDLE;
         int_reg          <= 1'b0;
         isr_reg          <= 8'd0;
         clear_irr_reg    <= 8'd0;
         vector_out_reg   <= 8'd0;
         vector_valid_reg <= 1'b0;
         end_of_ack_reg   <= 1'b0;
         ack_timeout_reg  <= 1'b0;
         cnt_reg          <= '0;
         level_reg        <= 3'd0;
         spurious_reg     <= 1'b0;
         int_ack_q        <= 1'b0;
      end else if (init) begin
         state_reg        <= S_IDLE;
         int_reg          <= 1'b0;
         isr_reg          <= 8'd0;
         clear_irr_reg    <= 8'd0;
         vector_out_reg   <= 8'd0;
         vector_valid_reg <= 1'b0;
         end_of_ack_reg   <= 1'b0;
         ack_timeout_reg  <= 1'b0;
         cnt_reg          <= '0;
         level_reg        <= 3'd0;
         spurious_reg     <= 1'b0;
         int_ack_q        <= int_ack;
      end else begin
         state_reg        <= state_next;
         int_reg          <= int_next;
         isr_reg          <= isr_next;
         clear_irr_reg    <= clear_irr_next;
         vector_out_reg   <= vector_out_next;
         vector_valid_reg <= vector_valid_next;
         end_of_ack_reg   <= end_of_ack_next;
         ack_timeout_reg  <= ack_timeout_next;
         cnt_reg          <= cnt_next;
         level_reg        <= level_next;
         spurious_reg     <= spurious_next;
         int_ack_q        <= int_ack;
      end
   end

   assign INT                      = int_reg;
   assign isr                      = isr_reg;
   assign highest_level_in_service = isr_found ? (8'd1 << isr_level) : 8'd0;
   assign clear_IRR                = clear_irr_reg;
   assign vector_out               = vector_out_reg;
   assign vector_valid             = vector_valid_reg;
   assign end_of_ack               = end_of_ack_reg;
   assign ack_timeout              = ack_timeout_reg;

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Directed bench for int_ack_sequencer; expected vectors are queued when a
// request is driven and popped when the DUT presents vector_valid.
module tb_int_ack_sequencer;

   logic       clk;
   logic       reset_n;
   logic       init;
   logic [7:0] irr;
   logic [7:0] int_mask;
   logic [7:0] eoi;
   logic [2:0] priority_rotate;
   logic       auto_eoi;
   logic [4:0] vector_base;
   logic       int_ack;
   logic       INT;
   logic [7:0] isr;
   logic [7:0] highest_level_in_service;
   logic [7:0] clear_IRR;
   logic [7:0] vector_out;
   logic       vector_valid;
   logic       end_of_ack;
   logic       ack_timeout;

   int compared   = 0;
   int mismatched = 0;
   logic [7:0] exp_vec_q[$];

   int_ack_sequencer #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .init                     (init),
      .irr                      (irr),
      .int_mask                 (int_mask),
      .eoi                      (eoi),
      .priority_rotate          (priority_rotate),
      .auto_eoi                 (auto_eoi),
      .vector_base              (vector_base),
      .int_ack                  (int_ack),
      .INT                      (INT),
      .isr                      (isr),
      .highest_level_in_service (highest_level_in_service),
      .clear_IRR                (clear_IRR),
      .vector_out               (vector_out),
      .vector_valid             (vector_valid),
      .end_of_ack               (end_of_ack),
      .ack_timeout              (ack_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic ack_rise();
      int_ack = 1'b1;
      step();
   endtask

   task automatic ack_fall();
      int_ack = 1'b0;
      step();
   endtask

   task automatic check_vector();
      logic [7:0] e;
      check("vec_queue_nonempty", 32'(exp_vec_q.size() != 0), 32'd1);
      e = 8'h00;
      if (exp_vec_q.size() != 0) e = exp_vec_q.pop_front();
      check("vector_valid", 32'(vector_valid), 32'd1);
      check("vector_out", 32'(vector_out), 32'(e));
      $display("vector: observed %02h expected %02h", vector_out, e);
   endtask

   // Full two-pulse acknowledge of one request expected to win at level lvl.
   task automatic full_seq(input logic [7:0] req, input logic [2:0] lvl, input bit do_eoi);
      logic [7:0] onehot;
      onehot = 8'd1 << lvl;
      irr = req;
      exp_vec_q.push_back({vector_base, lvl});
      step();
      check("int_rise", 32'(INT), 32'd1);
      ack_rise();
      check("isr_set", 32'(isr & onehot), 32'(onehot));
      check("clear_irr", 32'(clear_IRR), 32'(onehot));
      irr = 8'h00;
      ack_fall();
      check("clear_irr_one_cycle", 32'(clear_IRR), 32'd0);
      ack_rise();
      check_vector();
      ack_fall();
      check("end_of_ack", 32'(end_of_ack), 32'd1);
      check("int_drop", 32'(INT), 32'd0);
      check("vv_drop", 32'(vector_valid), 32'd0);
      check("isr_after", 32'(isr & onehot), auto_eoi ? 32'd0 : 32'(onehot));
      $display("seq: req %02h level %0d isr %02h", req, lvl, isr);
      if (do_eoi) begin
         eoi = onehot;
         step();
         eoi = 8'h00;
         step();
      end
   endtask

   initial begin
      reset_n = 1'b0; init = 1'b0; irr = 8'h00; int_mask = 8'h00; eoi = 8'h00;
      priority_rotate = 3'd7; auto_eoi = 1'b0; vector_base = 5'h11; int_ack = 1'b0;
      step();
      step();
      check("rst_int", 32'(INT), 32'd0);
      check("rst_isr", 32'(isr), 32'd0);
      check("rst_clear_irr", 32'(clear_IRR), 32'd0);
      check("rst_vector_out", 32'(vector_out), 32'd0);
      check("rst_vv", 32'(vector_valid), 32'd0);
      check("rst_eoa", 32'(end_of_ack), 32'd0);
      check("rst_timeout", 32'(ack_timeout), 32'd0);
      check("rst_hlis", 32'(highest_level_in_service), 32'd0);
      reset_n = 1'b1;
      step();

      // INTA in IDLE is ignored
      ack_rise();
      check("idle_ack_int", 32'(INT), 32'd0);
      check("idle_ack_clear", 32'(clear_IRR), 32'd0);
      ack_fall();

      // Single request IR4
      full_seq(8'h10, 3'd4, 1'b1);
      check("isr_eoi_cleared", 32'(isr), 32'd0);

      // Priority and rotation
      priority_rotate = 3'd0;
      full_seq(8'h81, 3'd7, 1'b1);
      priority_rotate = 3'd7;
      full_seq(8'h81, 3'd0, 1'b1);
      int_mask = 8'h01;
      full_seq(8'h81, 3'd7, 1'b1);
      int_mask = 8'h00;

      // Nesting: IR2 in service blocks IR4, IR0 is allowed through
      full_seq(8'h04, 3'd2, 1'b0);
      check("nest_isr", 32'(isr), 32'h04);
      check("nest_hlis", 32'(highest_level_in_service), 32'h04);
      irr = 8'h10;
      step();
      step();
      check("nest_blocked", 32'(INT), 32'd0);
      irr = 8'h01;
      step();
      check("nest_higher", 32'(INT), 32'd1);
      irr = 8'h00;
      step();
      check("withdraw_int", 32'(INT), 32'd0);
      irr = 8'h10;
      eoi = 8'h04;
      step();
      eoi = 8'h00;
      check("eoi_isr", 32'(isr), 32'd0);
      check("eoi_int_still_low", 32'(INT), 32'd0);
      step();
      check("eoi_int_next", 32'(INT), 32'd1);
      full_seq(8'h10, 3'd4, 1'b1);

      // Auto-EOI on and off
      auto_eoi = 1'b1;
      full_seq(8'h02, 3'd1, 1'b0);
      check("aeoi_isr", 32'(isr), 32'd0);
      auto_eoi = 1'b0;
      full_seq(8'h02, 3'd1, 1'b0);
      check("no_aeoi_isr", 32'(isr), 32'h02);
      eoi = 8'h02;
      step();
      eoi = 8'h00;

      // Spurious: request withdrawn on the INTA#1 rise
      irr = 8'h08;
      step();
      check("spur_int", 32'(INT), 32'd1);
      irr = 8'h00;
      exp_vec_q.push_back({vector_base, 3'd7});
      ack_rise();
      check("spur_isr", 32'(isr), 32'd0);
      check("spur_clear", 32'(clear_IRR), 32'd0);
      ack_fall();
      ack_rise();
      check_vector();
      ack_fall();
      check("spur_eoa", 32'(end_of_ack), 32'd1);
      check("spur_isr_end", 32'(isr), 32'd0);

      // Set beats EOI on the same bit
      irr = 8'h10;
      exp_vec_q.push_back({vector_base, 3'd4});
      step();
      int_ack = 1'b1;
      eoi = 8'h10;
      step();
      eoi = 8'h00;
      check("collide_isr", 32'(isr), 32'h10);
      irr = 8'h00;
      ack_fall();
      ack_rise();
      check_vector();
      ack_fall();
      eoi = 8'h10;
      step();
      eoi = 8'h00;
      step();

      // Timeout with ACK_TIMEOUT=4
      irr = 8'h20;
      step();
      ack_rise();
      check("to_isr_set", 32'(isr), 32'h20);
      irr = 8'h00;
      ack_fall();
      step();
      check("to_early1", 32'(ack_timeout), 32'd0);
      step();
      step();
      check("to_early3", 32'(ack_timeout), 32'd0);
      check("to_int_held", 32'(INT), 32'd1);
      step();
      check("to_pulse", 32'(ack_timeout), 32'd1);
      check("to_isr_clr", 32'(isr), 32'd0);
      check("to_int", 32'(INT), 32'd0);
      step();
      check("to_pulse_end", 32'(ack_timeout), 32'd0);
      $display("timeout: sequence aborted at cycle 4");

      // init during ACK2
      irr = 8'h40;
      exp_vec_q.push_back({vector_base, 3'd6});
      step();
      ack_rise();
      irr = 8'h00;
      ack_fall();
      ack_rise();
      check_vector();
      init = 1'b1;
      step();
      init = 1'b0;
      check("init_int", 32'(INT), 32'd0);
      check("init_isr", 32'(isr), 32'd0);
      check("init_vv", 32'(vector_valid), 32'd0);
      check("init_vo", 32'(vector_out), 32'd0);
      check("init_eoa", 32'(end_of_ack), 32'd0);
      check("init_to", 32'(ack_timeout), 32'd0);
      check("init_clear", 32'(clear_IRR), 32'd0);
      check("init_hlis", 32'(highest_level_in_service), 32'd0);
      ack_fall();
      check("init_no_eoa", 32'(end_of_ack), 32'd0);

      check("queue_drained", 32'(exp_vec_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
